rom_burst_arbiter: RTL and testbench

- Shares one synchronous-read ROM port (en/addr in, data out, 1-cycle read latency) between two requesters.
- Round-robin arbitration; each request is a burst of 1-4 consecutive words.
- Drives rom_en/rom_addr and routes returning rom_data to the owning requester with valid/last tagging.
- Sits between lookup clients (sequencers, table walkers) and the 16x4 rom block.

---
 rtl/rom_burst_arb_pkg.sv | 13 +
 rtl/rom_burst_arbiter_rr_arb2.sv | 19 +
 rtl/rom_burst_arbiter.sv | 150 +++++++++++++++
 tb/tb_rom_burst_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_arb_pkg.sv
// Shared types and constants for the ROM burst arbiter.
package rom_burst_arb_pkg;

  localparam int LEN_W      = 2;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-way round-robin picker: prefers the requester named by ptr,
// falls back to the other one when that requester is idle.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Pick the preferred requester if it is asking, otherwise the other.
  always_comb begin
    grant_idx = valid[ptr] ? ptr : ~ptr;
    grant     = 2'b00;
    if (|valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter in front of a synchronous-read ROM port.
// Optional per-requester grant counters: define ROM_BURST_ARBITER_PERF_EN.
//
// state | meaning
// IDLE  | no burst in flight; grants and issues the first beat same cycle
// BURST | issuing the remaining beats of the owner's burst
module rom_burst_arbiter
  import rom_burst_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_last,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_last,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_BURST_ARBITER_PERF_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  state_t              state, state_nxt;
  logic                rr_ptr;
  logic                owner;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    beats_left;
  logic                p_valid, p_owner, p_last;

  logic [1:0]          grant;
  logic                grant_idx;
  logic                accept;
  logic                issue_owner;
  logic                issue_last;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;

  rr_arb2 u_rr_arb2 (
    .valid     ({req1_valid, req0_valid}),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr = grant_idx ? req1_addr : req0_addr;
  assign sel_len  = grant_idx ? req1_len  : req0_len;

  // Grant/issue decode and next state; everything is held quiet while rst is high.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    issue_owner = owner;
    issue_last  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (|grant) begin
            accept      = 1'b1;
            req0_ready  = grant[0];
            req1_ready  = grant[1];
            rom_en      = 1'b1;
            rom_addr    = sel_addr;
            issue_owner = grant_idx;
            issue_last  = (sel_len == '0);
            state_nxt   = issue_last ? IDLE : BURST;
          end
        end
        BURST: begin
          rom_en      = 1'b1;
          rom_addr    = cur_addr + ADDR_W'(1);
          issue_owner = owner;
          issue_last  = (beats_left == LEN_W'(1));
          state_nxt   = issue_last ? IDLE : BURST;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Burst bookkeeping, round-robin pointer and one-deep response pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
      p_valid    <= 1'b0;
      p_owner    <= 1'b0;
      p_last     <= 1'b0;
    end else begin
      state   <= state_nxt;
      p_valid <= rom_en;
      p_owner <= issue_owner;
      p_last  <= issue_last;
      if (accept) begin
        owner      <= grant_idx;
        cur_addr   <= sel_addr;
        beats_left <= sel_len;
        rr_ptr     <= ~grant_idx;
      end else if (state == BURST) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - LEN_W'(1);
      end
    end
  end

  assign rsp0_valid = p_valid & ~p_owner & ~rst;
  assign rsp1_valid = p_valid &  p_owner & ~rst;
  assign rsp0_last  = rsp0_valid & p_last;
  assign rsp1_last  = rsp1_valid & p_last;
  assign rsp0_data  = rom_data;
  assign rsp1_data  = rom_data;

`ifdef ROM_BURST_ARBITER_PERF_EN
  // Saturating count of accepted bursts per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`else
  // Counters are not built in the default configuration.
`endif

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a 16x4 synchronous-read ROM model.
// Define ROM_BURST_ARBITER_PERF_EN to also exercise the grant counters.
module tb_rom_burst_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_addr, req1_addr;
  logic [1:0] req0_len, req1_len;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_data, rsp1_data;
  logic       rsp0_last, rsp1_last;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
`ifdef ROM_BURST_ARBITER_PERF_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  logic [3:0] mem [16];
  int n_total = 0;
  int n_pass  = 0;

  rom_burst_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_len   (req0_len),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_last  (rsp0_last),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_len   (req1_len),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_last  (rsp1_last),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
`ifdef ROM_BURST_ARBITER_PERF_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle read latency.
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'b0000;
    mem[0]  = 4'b0010;
    mem[1]  = 4'b0010;
    mem[2]  = 4'b1110;
    mem[5]  = 4'b1010;
    mem[14] = 4'b1100;
    mem[15] = 4'b0000;
    rom_data   = 4'b0000;
    rst        = 1'b1;
    req0_valid = 1'b0; req0_addr = 4'd0; req0_len = 2'd0;
    req1_valid = 1'b0; req1_addr = 4'd0; req1_len = 2'd0;

    // Reset
    tick(); tick(); #1;
    chk("rst_ready0", 8'(req0_ready), 8'd0);
    chk("rst_ready1", 8'(req1_ready), 8'd0);
    chk("rst_rom_en", 8'(rom_en), 8'd0);
    chk("rst_rom_addr", 8'(rom_addr), 8'd0);
    chk("rst_rsp_valid", 8'({rsp1_valid, rsp0_valid}), 8'd0);
    chk("rst_rsp_last", 8'({rsp1_last, rsp0_last}), 8'd0);
    tick(); rst = 1'b0; #1;
    chk("idle_rom_en", 8'(rom_en), 8'd0);
    chk("idle_rom_addr", 8'(rom_addr), 8'd0);

    // 1: single word from req0
    tick(); req0_valid = 1'b1; req0_addr = 4'd2; req0_len = 2'd0; #1;
    chk("t1_ready0", 8'(req0_ready), 8'd1);
    chk("t1_ready1", 8'(req1_ready), 8'd0);
    chk("t1_rom_en", 8'(rom_en), 8'd1);
    chk("t1_rom_addr", 8'(rom_addr), 8'd2);
    tick(); req0_valid = 1'b0; #1;
    chk("t1_rsp0_valid", 8'(rsp0_valid), 8'd1);
    chk("t1_rsp0_data", 8'(rsp0_data), 8'b1110);
    chk("t1_rsp0_last", 8'(rsp0_last), 8'd1);
    chk("t1_rsp1_valid", 8'(rsp1_valid), 8'd0);
    chk("t1_rom_en_off", 8'(rom_en), 8'd0);

    // 2: 4-beat wrapping burst from req1
    tick(); req1_valid = 1'b1; req1_addr = 4'd14; req1_len = 2'd3; #1;
    chk("t2_ready1", 8'(req1_ready), 8'd1);
    chk("t2_addr0", 8'(rom_addr), 8'd14);
    tick(); req1_valid = 1'b0; #1;
    chk("t2_ready1_b1", 8'(req1_ready), 8'd0);
    chk("t2_addr1", 8'(rom_addr), 8'd15);
    chk("t2_en1", 8'(rom_en), 8'd1);
    chk("t2_rsp_v0", 8'(rsp1_valid), 8'd1);
    chk("t2_rsp_d0", 8'(rsp1_data), 8'b1100);
    chk("t2_rsp_l0", 8'(rsp1_last), 8'd0);
    tick(); #1;
    chk("t2_ready1_b2", 8'(req1_ready), 8'd0);
    chk("t2_addr2", 8'(rom_addr), 8'd0);
    chk("t2_rsp_v1", 8'(rsp1_valid), 8'd1);
    chk("t2_rsp_d1", 8'(rsp1_data), 8'b0000);
    chk("t2_rsp_l1", 8'(rsp1_last), 8'd0);
    tick(); #1;
    chk("t2_addr3", 8'(rom_addr), 8'd1);
    chk("t2_rsp_v2", 8'(rsp1_valid), 8'd1);
    chk("t2_rsp_d2", 8'(rsp1_data), 8'b0010);
    chk("t2_rsp_l2", 8'(rsp1_last), 8'd0);
    tick(); #1;
    chk("t2_en_end", 8'(rom_en), 8'd0);
    chk("t2_rsp_v3", 8'(rsp1_valid), 8'd1);
    chk("t2_rsp_d3", 8'(rsp1_data), 8'b0010);
    chk("t2_rsp_l3", 8'(rsp1_last), 8'd1);
    chk("t2_rsp0_quiet", 8'(rsp0_valid), 8'd0);

    // 3: both valid right after reset
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    req0_valid = 1'b1; req0_addr = 4'd5; req0_len = 2'd0;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_len = 2'd0; #1;
    chk("t3_ready0", 8'(req0_ready), 8'd1);
    chk("t3_ready1", 8'(req1_ready), 8'd0);
    chk("t3_addr0", 8'(rom_addr), 8'd5);
    tick(); req0_valid = 1'b0; #1;
    chk("t3_ready1b", 8'(req1_ready), 8'd1);
    chk("t3_ready0b", 8'(req0_ready), 8'd0);
    chk("t3_addr1", 8'(rom_addr), 8'd2);
    chk("t3_rsp0_v", 8'(rsp0_valid), 8'd1);
    chk("t3_rsp0_d", 8'(rsp0_data), 8'b1010);
    chk("t3_rsp1_v0", 8'(rsp1_valid), 8'd0);
    tick(); req1_valid = 1'b0; #1;
    chk("t3_rsp1_v", 8'(rsp1_valid), 8'd1);
    chk("t3_rsp1_d", 8'(rsp1_data), 8'b1110);
    chk("t3_rsp0_v1", 8'(rsp0_valid), 8'd0);

    // 4: continuous contention, single-word requests alternate
    tick();
    req0_valid = 1'b1; req0_addr = 4'd0; req0_len = 2'd0;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_len = 2'd0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); #1; end
      chk("t4_ready0", 8'(req0_ready), (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("t4_ready1", 8'(req1_ready), (i % 2 == 1) ? 8'd1 : 8'd0);
      chk("t4_rom_en", 8'(rom_en), 8'd1);
      chk("t4_rom_addr", 8'(rom_addr), (i % 2 == 0) ? 8'd0 : 8'd5);
      if (i > 0) begin
        chk("t4_rsp0_v", 8'(rsp0_valid), (i % 2 == 1) ? 8'd1 : 8'd0);
        chk("t4_rsp1_v", 8'(rsp1_valid), (i % 2 == 0) ? 8'd1 : 8'd0);
        chk("t4_rsp_d", 8'(rsp0_valid ? rsp0_data : rsp1_data),
            (i % 2 == 1) ? 8'b0010 : 8'b1010);
      end
    end
    tick(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk("t4_rsp1_tail", 8'(rsp1_valid), 8'd1);
    chk("t4_rsp1_tail_d", 8'(rsp1_data), 8'b1010);
    chk("t4_rsp0_tail", 8'(rsp0_valid), 8'd0);

    // 5: reset mid-burst, pointer restored to requester 0
    tick(); req0_valid = 1'b1; req0_addr = 4'd0; req0_len = 2'd3; #1;
    chk("t5_ready0", 8'(req0_ready), 8'd1);
    tick(); req0_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t5_rom_en", 8'(rom_en), 8'd0);
    chk("t5_rsp0_v", 8'(rsp0_valid), 8'd0);
    chk("t5_rsp1_v", 8'(rsp1_valid), 8'd0);
    tick();
    req0_valid = 1'b1; req0_addr = 4'd2; req0_len = 2'd0;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_len = 2'd0; #1;
    chk("t5_win0", 8'(req0_ready), 8'd1);
    chk("t5_lose1", 8'(req1_ready), 8'd0);
    tick(); req0_valid = 1'b0; #1;
    chk("t5_ready1", 8'(req1_ready), 8'd1);
    chk("t5_rsp0_d", 8'(rsp0_data), 8'b1110);
    tick(); req1_valid = 1'b0; #1;
    chk("t5_rsp1_d", 8'(rsp1_data), 8'b1010);

`ifdef ROM_BURST_ARBITER_PERF_EN
    // 6: grant counters
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t6_cnt0_rst", grant_cnt0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); req0_valid = 1'b1; req0_addr = 4'd1; req0_len = 2'd0;
      tick(); req0_valid = 1'b0;
    end
    #1;
    chk("t6_cnt0_3", grant_cnt0, 8'd3);
    chk("t6_cnt1_0", grant_cnt1, 8'd0);
    tick(); req0_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    req0_valid = 1'b0;
    tick(); #1;
    chk("t6_cnt0_sat", grant_cnt0, 8'd255);
    chk("t6_cnt1_still0", grant_cnt1, 8'd0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
